// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time over a req/gnt/rvalid bus,
// with store lane steering, load extraction, alignment/func3 faults and a bus timeout.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_func3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_addr_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] err_addr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: the bus samples mem_req_o with its address/be/we/wdata on every
  // cycle in REQ; the transfer completes on the cycle mem_gnt_i is high. For a
  // load, exactly one later cycle with mem_rvalid_i high carries mem_rdata_i.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;

  logic        r_rd_wen;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [31:0] r_err_addr;

  logic        w_illegal;
  logic        w_misal;
  logic        w_idle_req;
  logic        w_accept;
  logic        w_done;
  logic        w_tmo;
  logic        w_in_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load;

  // Illegal func3 takes priority over misalignment.
  always_comb begin
    w_illegal = (req_func3_i == 3'b011) || (req_func3_i[2:1] == 2'b11) ||
                (req_we_i && req_func3_i[2]);
    w_misal   = ((req_func3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                ((req_func3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  assign w_idle_req = (r_state == IDLE) && req_valid_i;
  assign w_accept   = w_idle_req && !w_illegal && !w_misal;
  assign w_done     = ((r_state == REQ) && mem_gnt_i) || ((r_state == RSP) && mem_rvalid_i);
  assign w_tmo      = (r_state != IDLE) && !w_done && (r_cnt == LastCnt);
  assign w_in_req   = (r_state == REQ);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = REQ;
      REQ: begin
        if (mem_gnt_i)  w_next = r_we ? IDLE : RSP;
        else if (w_tmo) w_next = IDLE;
      end
      RSP: begin
        if (mem_rvalid_i) w_next = IDLE;
        else if (w_tmo)   w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Byte enables and replicated store data from the captured request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_lane = mem_rdata_i >> {r_addr[1:0], 3'b000};
    case (r_func3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_func3    <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 5'd0;
      r_cnt      <= 8'd0;
      r_rd_wen   <= 1'b0;
      r_rd_addr  <= 5'd0;
      r_rd_data  <= 32'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_err_addr <= 32'd0;
    end else begin
      r_rd_wen   <= 1'b0;
      r_rd_addr  <= 5'd0;
      r_rd_data  <= 32'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_err_addr <= 32'd0;

      if (w_accept) begin
        r_we    <= req_we_i;
        r_func3 <= req_func3_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_rd    <= req_rd_addr_i;
        r_cnt   <= 8'd0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_idle_req && w_illegal) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
        r_err_addr <= req_addr_i;
      end else if (w_idle_req && w_misal) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
        r_err_addr <= req_addr_i;
      end

      if (w_tmo) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b11;
        r_err_addr <= r_addr;
      end

      // Writes to x0 are dropped entirely so rd_* stay zero.
      if ((r_state == RSP) && mem_rvalid_i && (r_rd != 5'd0)) begin
        r_rd_wen  <= 1'b1;
        r_rd_addr <= r_rd;
        r_rd_data <= w_load;
      end
    end
  end

  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req && r_we;
  assign mem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_be_o    = w_in_req ? w_be : 4'd0;
  assign mem_wdata_o = (w_in_req && r_we) ? w_wdata : 32'd0;

  assign hold_flag_o = w_accept || (r_state != IDLE);

  assign rd_wen_o    = r_rd_wen;
  assign rd_addr_o   = r_rd_addr;
  assign rd_data_o   = r_rd_data;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
  assign err_addr_o  = r_err_addr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed loads/stores/faults/timeouts/reset against a
// transaction-level model checked every cycle, plus hand-computed literals.
module tb_lsu;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_func3_i = 3'd0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic [4:0]  req_rd_addr_i = 5'd0;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic        hold_flag_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [31:0] err_addr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic [1:0]  dbg_state_o;

  lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_func3_i(req_func3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_addr_i(req_rd_addr_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .hold_flag_o(hold_flag_o), .err_o(err_o), .err_code_o(err_code_o), .err_addr_o(err_addr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- model helpers ----------------
  function automatic bit m_illegal(input logic we, input logic [2:0] f);
    return (f == 3) || (f == 6) || (f == 7) || (we && f >= 4);
  endfunction

  function automatic bit m_misal(input logic [2:0] f, input logic [31:0] a);
    int sz = f % 4;
    return (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int sz = f % 4;
    int off = a % 4;
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
    int sz = f % 4;
    if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- transaction model ----------------
  bit          m_busy = 1'b0;
  bit          m_granted = 1'b0;
  int          m_wait = 0;
  logic        t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wd;
  logic [4:0]  t_rd;
  logic        e_wen = 1'b0;
  logic [4:0]  e_rda = 5'd0;
  logic [31:0] e_rdd = 32'd0;
  logic        e_err = 1'b0;
  logic [1:0]  e_code = 2'd0;
  logic [31:0] e_eaddr = 32'd0;

  initial forever begin
    @(posedge clk);
    e_wen = 1'b0; e_rda = 5'd0; e_rdd = 32'd0;
    e_err = 1'b0; e_code = 2'd0; e_eaddr = 32'd0;
    if (rst) begin
      m_busy = 1'b0;
      m_granted = 1'b0;
    end else if (!m_busy) begin
      if (req_valid_i) begin
        if (m_illegal(req_we_i, req_func3_i)) begin
          e_err = 1'b1; e_code = 2'd2; e_eaddr = req_addr_i;
        end else if (m_misal(req_func3_i, req_addr_i)) begin
          e_err = 1'b1; e_code = 2'd1; e_eaddr = req_addr_i;
        end else begin
          m_busy = 1'b1; m_granted = 1'b0; m_wait = 0;
          t_we = req_we_i; t_f3 = req_func3_i; t_addr = req_addr_i;
          t_wd = req_wdata_i; t_rd = req_rd_addr_i;
        end
      end
    end else begin
      m_wait++;
      if (!m_granted && mem_gnt_i) begin
        if (t_we) m_busy = 1'b0;
        else      m_granted = 1'b1;
      end else if (m_granted && mem_rvalid_i) begin
        m_busy = 1'b0;
        if (t_rd != 0) begin
          e_wen = 1'b1; e_rda = t_rd; e_rdd = m_load(t_f3, t_addr, mem_rdata_i);
        end
      end else if (m_wait == TMO) begin
        m_busy = 1'b0;
        e_err = 1'b1; e_code = 2'd3; e_eaddr = t_addr;
      end
    end
  end

  // ---------------- compare process and monitors ----------------
  int          wen_count, err_count, req_cycles, hold_cycles;
  logic [1:0]  last_err_code;
  logic [31:0] last_err_addr, last_addr, last_wdata, last_rd_data;
  logic [3:0]  last_be;
  logic [4:0]  last_rd_addr;
  logic        x_req, x_hold;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      x_req  = m_busy && !m_granted;
      x_hold = m_busy || (req_valid_i && !m_illegal(req_we_i, req_func3_i) &&
                          !m_misal(req_func3_i, req_addr_i));
      chk("rd_wen", rd_wen_o, e_wen);
      chk("rd_addr", rd_addr_o, e_rda);
      chk("rd_data", rd_data_o, e_rdd);
      chk("err", err_o, e_err);
      chk("err_code", err_code_o, e_code);
      chk("err_addr", err_addr_o, e_eaddr);
      chk("hold", hold_flag_o, x_hold);
      chk("mem_req", mem_req_o, x_req);
      chk("mem_we", mem_we_o, x_req && t_we);
      chk("mem_addr", mem_addr_o, x_req ? (t_addr & 32'hFFFFFFFC) : 32'd0);
      chk("mem_be", mem_be_o, x_req ? m_be(t_f3, t_addr) : 4'd0);
      chk("mem_wdata", mem_wdata_o, (x_req && t_we) ? m_wdata(t_f3, t_wd) : 32'd0);
    end
    if (rd_wen_o) begin
      wen_count++;
      last_rd_addr = rd_addr_o;
      last_rd_data = rd_data_o;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected actual=%h required=none", rd_data_o);
      end else begin
        chk("wb_scoreboard", rd_data_o, exp_q.pop_front());
      end
    end
    if (err_o) begin
      err_count++;
      last_err_code = err_code_o;
      last_err_addr = err_addr_o;
    end
    if (mem_req_o) begin
      req_cycles++;
      last_addr = mem_addr_o; last_be = mem_be_o; last_wdata = mem_wdata_o;
    end
    if (hold_flag_o) hold_cycles++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wen_count = 0; err_count = 0; req_cycles = 0; hold_cycles = 0;
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_valid_i = 1'b1; req_we_i = we; req_func3_i = f3;
    req_addr_i = a; req_wdata_i = wd; req_rd_addr_i = rd;
    step();
    req_valid_i = 1'b0; req_we_i = 1'b0; req_func3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; req_rd_addr_i = 5'd0;
  endtask

  // gd: cycles without grant; rvd: cycles without rvalid after grant (-1 = never).
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [4:0] rd, input int gd,
                    input int rvd, input logic [31:0] rdat, input bit push,
                    input logic [31:0] exp_wb);
    clear_mon();
    if (push) exp_q.push_back(exp_wb);
    present(we, f3, a, wd, rd);
    repeat (gd) step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    if (!we) begin
      if (rvd >= 0) begin
        repeat (rvd) step();
        mem_rvalid_i = 1'b1; mem_rdata_i = rdat;
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
      end else begin
        repeat (TMO + 2) step();
      end
    end
    repeat (3) step();
  endtask

  task automatic fault(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [1:0] code);
    clear_mon();
    present(we, f3, a, 32'h12345678, 5'd3);
    repeat (2) step();
    chk("fault_count", err_count, 1);
    chk("fault_code", last_err_code, code);
    chk("fault_addr", last_err_addr, a);
    chk("fault_no_req", req_cycles, 0);
    chk("fault_no_hold", hold_cycles, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_hold", hold_flag_o, 0);
    chk("reset_rd_wen", rd_wen_o, 0);
    chk("reset_err", err_o, 0);
    step();

    // LW, zero wait
    op(1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    chk("lw_be", last_be, 4'b1111);
    chk("lw_addr", last_addr, 32'h100);
    chk("lw_req_cycles", req_cycles, 1);
    chk("lw_hold_cycles", hold_cycles, 3);
    chk("lw_wen_count", wen_count, 1);
    chk("lw_rd", last_rd_addr, 5);
    chk("lw_data", last_rd_data, 32'hDEADBEEF);

    // LB vs LBU
    op(1'b0, 3'b000, 32'h103, 32'd0, 5'd6, 0, 0, 32'h80112233, 1'b1, 32'hFFFFFF80);
    chk("lb_be", last_be, 4'b1000);
    chk("lb_data", last_rd_data, 32'hFFFFFF80);
    op(1'b0, 3'b100, 32'h103, 32'd0, 5'd7, 1, 1, 32'h80112233, 1'b1, 32'h00000080);
    chk("lbu_data", last_rd_data, 32'h00000080);

    // LH / LHU on the upper half
    op(1'b0, 3'b001, 32'h102, 32'd0, 5'd8, 0, 2, 32'h80112233, 1'b1, 32'hFFFF8011);
    chk("lh_be", last_be, 4'b1100);
    op(1'b0, 3'b101, 32'h102, 32'd0, 5'd9, 2, 0, 32'h12345678, 1'b1, 32'h00001234);
    chk("lhu_data", last_rd_data, 32'h00001234);

    // SH with delayed grant
    op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 3, 0, 32'd0, 1'b0, 32'd0);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_req_cycles", req_cycles, 4);
    chk("sh_hold_cycles", hold_cycles, 5);
    chk("sh_no_wb", wen_count, 0);

    // SB / SW
    op(1'b1, 3'b000, 32'h301, 32'h1234565A, 5'd0, 0, 0, 32'd0, 1'b0, 32'd0);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    op(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0, 1, 0, 32'd0, 1'b0, 32'd0);
    chk("sw_wdata", last_wdata, 32'hCAFEF00D);
    chk("sw_hold_cycles", hold_cycles, 3);

    // Faults
    fault(1'b0, 3'b010, 32'h101, 2'b01);
    fault(1'b0, 3'b011, 32'h200, 2'b10);
    fault(1'b1, 3'b100, 32'h204, 2'b10);
    fault(1'b0, 3'b111, 32'h003, 2'b10);
    fault(1'b0, 3'b001, 32'h201, 2'b01);

    // Timeout in RSP, then rvalid exactly on the last allowed cycle
    op(1'b0, 3'b010, 32'h600, 32'd0, 5'd10, 0, -1, 32'd0, 1'b0, 32'd0);
    chk("tmo_err_count", err_count, 1);
    chk("tmo_code", last_err_code, 2'b11);
    chk("tmo_addr", last_err_addr, 32'h600);
    chk("tmo_no_wb", wen_count, 0);
    chk("tmo_hold_cycles", hold_cycles, 17);
    op(1'b0, 3'b010, 32'h604, 32'd0, 5'd11, 0, 14, 32'h13579BDF, 1'b1, 32'h13579BDF);
    chk("edge_no_err", err_count, 0);
    chk("edge_wb", wen_count, 1);

    // Timeout in REQ; the late grant lands in IDLE
    op(1'b1, 3'b010, 32'h700, 32'h11111111, 5'd0, 20, 0, 32'd0, 1'b0, 32'd0);
    chk("req_tmo_code", last_err_code, 2'b11);
    chk("req_tmo_addr", last_err_addr, 32'h700);
    chk("req_tmo_req_cycles", req_cycles, 16);

    // Load to x0
    op(1'b0, 3'b010, 32'h100, 32'd0, 5'd0, 0, 0, 32'hFFFFFFFF, 1'b0, 32'd0);
    chk("x0_no_wb", wen_count, 0);

    // Reset while waiting in RSP, stale rvalid afterwards
    clear_mon();
    present(1'b0, 3'b010, 32'h500, 32'd0, 5'd12);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req_o, 0);
    chk("rst_mid_hold", hold_flag_o, 0);
    chk("rst_mid_addr", mem_addr_o, 0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) step();
    chk("rst_stale_no_wb", wen_count, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
